// File: rtl/regfile_sb_pkg.sv
// Shared constants, read-source encoding and sizing helper for the
// scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Read-port data source; the two bypass entries are listed in priority order.
  typedef enum logic [1:0] {
    SRC_STORE,
    SRC_ZERO,
    SRC_BYP_A,
    SRC_BYP_B
  } rd_src_e;

  function automatic int unsigned busy_cnt_w(input int unsigned nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking for long-latency writebacks, incremental
// busy population count, and the sticky hazard-violation flag.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS),
  localparam int unsigned CW       = busy_cnt_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic [CW-1:0]    busy_cnt,
  output logic             hz_err
);

  logic             w_prot_a;
  logic             w_prot_b;
  logic             w_rsv_eff;
  logic             w_inc;
  logic             w_dec;
  logic             w_hz;
  logic [NREGS-1:0] w_busy_nxt;

  assign w_prot_a  = (ZERO_REG != 0) && (wa_a == '0);
  assign w_prot_b  = (ZERO_REG != 0) && (wa_b == '0);
  assign w_rsv_eff = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Set is applied after clear so a same-cycle reserve wins.
  always_comb begin
    w_busy_nxt = busy_vec;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (we_b)      w_busy_nxt[wa_b]     = 1'b0;
      if (w_rsv_eff) w_busy_nxt[rsv_addr] = 1'b1;
    end
  end

  assign w_inc = w_rsv_eff && !busy_vec[rsv_addr];
  assign w_dec = we_b && busy_vec[wa_b] && !(w_rsv_eff && (rsv_addr == wa_b));

  assign w_hz = (we_a && we_b && !w_prot_a && (wa_a == wa_b))
             || (we_a && !w_prot_a && busy_vec[wa_a])
             || (w_rsv_eff && busy_vec[rsv_addr] && !(we_b && (wa_b == rsv_addr)))
             || (we_b && !w_prot_b && !busy_vec[wa_b] && !flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
      hz_err   <= 1'b0;
    end else begin
      busy_vec <= w_busy_nxt;
      if (flush) busy_cnt <= '0;
      else       busy_cnt <= busy_cnt + CW'(w_inc) - CW'(w_dec);
      if (w_hz) hz_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports, combinational read
// ports with write bypass, and a busy scoreboard for long-latency ops.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NREGS),
  localparam int unsigned CW       = busy_cnt_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we_a,
  input  logic [AW-1:0]       wa_a,
  input  logic [XLEN-1:0]     wd_a,
  input  logic                we_b,
  input  logic [AW-1:0]       wa_b,
  input  logic [XLEN-1:0]     wd_b,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  output logic [CW-1:0]       busy_cnt,
  output logic                hz_err
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_prot_a;
  logic            w_prot_b;

  assign w_prot_a = (ZERO_REG != 0) && (wa_a == '0);
  assign w_prot_b = (ZERO_REG != 0) && (wa_b == '0);

  // Port A is written last so it overrides port B on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      if (we_b && !w_prot_b) r_mem[wa_b] <= wd_b;
      if (we_a && !w_prot_a) r_mem[wa_a] <= wd_a;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    rd_src_e         w_src;
    logic [XLEN-1:0] w_data;

    assign w_addr = rs_addr[k*AW +: AW];

    always_comb begin
      w_src = SRC_STORE;
      if ((ZERO_REG != 0) && (w_addr == '0))               w_src = SRC_ZERO;
      else if ((BYPASS != 0) && we_a && (wa_a == w_addr))  w_src = SRC_BYP_A;
      else if ((BYPASS != 0) && we_b && (wa_b == w_addr))  w_src = SRC_BYP_B;
    end

    always_comb begin
      case (w_src)
        SRC_ZERO:  w_data = '0;
        SRC_BYP_A: w_data = wd_a;
        SRC_BYP_B: w_data = wd_b;
        default:   w_data = r_mem[w_addr];
      endcase
    end

    assign rs_data[k*XLEN +: XLEN] = w_data;
    assign rs_busy[k] = busy_vec[w_addr] && !((BYPASS != 0) && we_b && (wa_b == w_addr));
  end

  regfile_sb_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we_a      (we_a),
    .wa_a      (wa_a),
    .we_b      (we_b),
    .wa_b      (wa_b),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt),
    .hz_err    (hz_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: integer-file instance (x0 hardwired) plus
// an F-file instance (f0 ordinary) driven by the same stimulus.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic                we_a, we_b, rsv_valid, flush;
  logic [AW-1:0]       wa_a, wa_b, rsv_addr;
  logic [XLEN-1:0]     wd_a, wd_b;

  logic [NRD*XLEN-1:0] rs_data_i, rs_data_f;
  logic [NRD-1:0]      rs_busy_i, rs_busy_f;
  logic [NREGS-1:0]    busy_vec_i, busy_vec_f;
  logic [CW-1:0]       busy_cnt_i, busy_cnt_f;
  logic                hz_err_i, hz_err_f;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) u_int (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_i), .rs_busy(rs_busy_i),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec_i), .busy_cnt(busy_cnt_i), .hz_err(hz_err_i)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0), .BYPASS(1)) u_f (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_f), .rs_busy(rs_busy_f),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec_f), .busy_cnt(busy_cnt_f), .hz_err(hz_err_f)
  );

  typedef struct {
    logic        we_a;  logic [4:0] wa_a;  logic [31:0] wd_a;
    logic        we_b;  logic [4:0] wa_b;  logic [31:0] wd_b;
    logic        rsv;   logic [4:0] rsv_a;
    logic [4:0]  rs0;   logic [4:0] rs1;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_bz0; logic        e_bz1;
    logic [5:0]  e_cnt; logic        e_hz;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic ea, input logic [4:0] aa, input logic [31:0] da,
    input logic eb, input logic [4:0] ab, input logic [31:0] db,
    input logic rv, input logic [4:0] ra, input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1,
    input logic [5:0] c, input logic h);
    vec_t v;
    v.we_a = ea; v.wa_a = aa; v.wd_a = da;
    v.we_b = eb; v.wa_b = ab; v.wd_b = db;
    v.rsv = rv; v.rsv_a = ra; v.rs0 = r0; v.rs1 = r1;
    v.e_rd0 = d0; v.e_rd1 = d1; v.e_bz0 = b0; v.e_bz1 = b1;
    v.e_cnt = c; v.e_hz = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ea, input logic [4:0] aa, input logic [31:0] da,
                       input logic eb, input logic [4:0] ab, input logic [31:0] db,
                       input logic rv, input logic [4:0] ra, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    we_a = ea; wa_a = aa; wd_a = da;
    we_b = eb; wa_b = ab; wd_b = db;
    rsv_valid = rv; rsv_addr = ra; flush = fl;
    rs_addr = {r1, r0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    we_a = 0; wa_a = 0; wd_a = 0; we_b = 0; wa_b = 0; wd_b = 0;
    rsv_valid = 0; rsv_addr = 0; flush = 0; rs_addr = {5'd5, 5'd7};

    //        ea aa  da            eb ab  db            rv ra  rs0 rs1  rd0           rd1           b0 b1 cnt h
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 0,          0, 0,  5,  0, 32'h1234, 32'h0,    0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  5,  5, 32'h1234, 32'h1234, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,          1, 9,  9,  5, 32'h0,    32'h1234, 0, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  9,  9, 32'h0,    32'h0,    1, 1, 1, 0);
    vecs[4]  = mk(0, 0, 0,        1, 9, 32'h55,     0, 0,  9,  5, 32'h55,   32'h1234, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  9,  9, 32'h55,   32'h55,   0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,        0, 0, 0,          1, 3,  3,  9, 32'h0,    32'h55,   0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0,        1, 3, 32'h77,     1, 3,  3,  3, 32'h77,   32'h77,   0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  3,  0, 32'h77,   32'h0,    1, 0, 1, 0);
    vecs[9]  = mk(1, 0, 32'hDEAD, 0, 0, 0,          1, 0,  0,  3, 32'h0,    32'h77,   0, 1, 1, 0);
    vecs[10] = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  5, 32'h0,    32'h1234, 0, 0, 1, 0);
    vecs[11] = mk(1, 10, 32'hA10, 1, 3, 32'h3333,   0, 0, 10,  3, 32'hA10,  32'h3333, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,        0, 0, 0,          0, 0, 10,  3, 32'hA10,  32'h3333, 0, 0, 0, 0);

    #2;
    chk("reset rd0", 64'(rs_data_i[31:0]), 64'h0);
    chk("reset rd1", 64'(rs_data_i[63:32]), 64'h0);
    chk("reset busy_vec", 64'(busy_vec_i), 64'h0);
    chk("reset busy_cnt", 64'(busy_cnt_i), 64'h0);
    chk("reset hz_err", 64'(hz_err_i), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we_a, vecs[i].wa_a, vecs[i].wd_a, vecs[i].we_b, vecs[i].wa_b, vecs[i].wd_b,
            vecs[i].rsv, vecs[i].rsv_a, 1'b0, vecs[i].rs0, vecs[i].rs1);
      chk($sformatf("v%0d rd0", i), 64'(rs_data_i[31:0]), 64'(vecs[i].e_rd0));
      chk($sformatf("v%0d rd1", i), 64'(rs_data_i[63:32]), 64'(vecs[i].e_rd1));
      chk($sformatf("v%0d busy0", i), 64'(rs_busy_i[0]), 64'(vecs[i].e_bz0));
      chk($sformatf("v%0d busy1", i), 64'(rs_busy_i[1]), 64'(vecs[i].e_bz1));
      tick();
      chk($sformatf("v%0d busy_cnt", i), 64'(busy_cnt_i), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d hz_err", i), 64'(hz_err_i), 64'(vecs[i].e_hz));
    end

    // ZERO_REG=0 instance: f0 is ordinary storage and can go busy.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0 int rd", 64'(rs_data_i[31:0]), 64'h0);
    chk("x0 int busy_vec", 64'(busy_vec_i), 64'h0);
    chk("f0 rd", 64'(rs_data_f[31:0]), 64'hDEAD);
    chk("f0 busy", 64'(busy_vec_f[0]), 64'h1);

    // Fill three busy bits, then flush alongside a new reserve.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    chk("fill busy_cnt", 64'(busy_cnt_i), 64'd3);
    chk("fill busy_vec", 64'(busy_vec_i), 64'h0000_000E);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0); tick();
    chk("flush busy_vec", 64'(busy_vec_i), 64'h0);
    chk("flush busy_cnt", 64'(busy_cnt_i), 64'h0);
    chk("flush hz_err", 64'(hz_err_i), 64'h0);
    drive(0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 0, 0); tick();
    chk("orphan hz_err", 64'(hz_err_i), 64'h1);

    // Asynchronous reset mid-cycle with a busy register outstanding.
    drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    chk("pre-rst rd0", 64'(rs_data_i[31:0]), 64'h1234);
    chk("pre-rst busy_cnt", 64'(busy_cnt_i), 64'd1);
    rst = 1'b1;
    #1;
    chk("async rst rd0", 64'(rs_data_i[31:0]), 64'h0);
    chk("async rst busy_cnt", 64'(busy_cnt_i), 64'h0);
    chk("async rst hz_err", 64'(hz_err_i), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Same-address A/B collision: A wins, flag raised.
    drive(1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0, 0, 7, 0);
    chk("collide bypass rd0", 64'(rs_data_i[31:0]), 64'hAAAA);
    tick();
    chk("collide hz_err", 64'(hz_err_i), 64'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    chk("collide stored", 64'(rs_data_i[63:32]), 64'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the RV32ICMFA pipeline, instantiated once for the integer file (x0 hardwired to zero) and once for the F file (f0 writable).
- Provides NRD combinational read ports with write-to-read bypass.
- Has two write ports:
  - A: in-order writeback.
  - B: late writeback from the long-latency M/F units.
- Holds a per-register busy scoreboard: set on issue of a long-latency op, cleared by its port-B writeback.
- Decode stalls on the per-read-port busy outputs.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers (power of two, >= 2).
- AW, $clog2(NREGS), register address width (derived; not overridden).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- rs_addr, in, NRD*AW, packed read addresses; port k at [k*AW +: AW].
- rs_data, out, NRD*XLEN, packed read data, combinational.
- rs_busy, out, NRD, per-port: source register has an outstanding long-latency write.
- we_a, in, 1, port A write enable.
- wa_a, in, AW, port A write address.
- wd_a, in, XLEN, port A write data.
- we_b, in, 1, port B write enable; also clears the busy bit of wa_b.
- wa_b, in, AW, port B write address.
- wd_b, in, XLEN, port B write data.
- rsv_valid, in, 1, reserve rsv_addr (mark busy) this cycle.
- rsv_addr, in, AW, register being reserved.
- flush, in, 1, clear all busy bits (pipeline kill of outstanding long-latency ops).
- busy_vec, out, NREGS, registered busy bits.
- busy_cnt, out, $clog2(NREGS+1), registered population count of busy_vec.
- hz_err, out, 1, sticky hazard-violation flag; cleared only by rst.

Behaviour:
- Reset (async, rst=1): all registers = 0; busy_vec = 0; busy_cnt = 0; hz_err = 0. rs_data then reads 0 for every address.
- Address 0 is "protected" when ZERO_REG=1:
  - rs_data = 0 for that port.
  - Writes are dropped.
  - rsv_valid to it is ignored.
  - It never appears in busy_vec.
  - Its writes never raise hz_err.
- Write, per rising edge:
  - we_a writes wd_a to wa_a; we_b writes wd_b to wa_b.
  - Both enabled with wa_a == wa_b: port A wins, B's data is discarded, hz_err sets.
- Read, combinational. With BYPASS=1, per port k, first match wins:
  1. Protected address: 0.
  2. we_a && wa_a == addr: wd_a.
  3. we_b && wa_b == addr: wd_b.
  4. Otherwise the stored value.
- With BYPASS=0, reads return the stored value (post-edge values are visible in the next cycle).
- Scoreboard next state, per register r:
  - busy'[r] = 0 if flush.
  - Else 1 if rsv_valid && rsv_addr == r.
  - Else 0 if we_b && wa_b == r.
  - Else busy[r].
  - So a same-cycle reserve beats a clear; flush beats everything.
- rs_busy[k] = busy[addr_k] && !(we_b && wa_b == addr_k && BYPASS). A same-cycle port-B writeback releases the stall because bypass supplies the data.
- busy_cnt always equals popcount(busy_vec) and is updated in the same edge as busy_vec. The counter is maintained incrementally (+1 on set of a clear bit, -1 on clear of a set bit, both in one cycle allowed); it is not recomputed from busy_vec.
- hz_err sets at the edge following any of:
  - Port A/B same-address collision.
  - we_a to a busy register (WAW against an outstanding op).
  - rsv_valid to an already-busy register without a same-cycle port-B clear of it.
  - we_b to a non-busy register while flush=0 (orphan writeback).
- Writes still take effect when hz_err is raised.
- flush does not block same-cycle writes: the data writes still happen and only the busy state is cleared.

Decomposition:
- Shared package holds:
  - Default XLEN/NREGS constants.
  - The busy_cnt width function.
  - Named constants for the two bypass priorities.
- One natural sub-module, regfile_sb_scoreboard, owns busy_vec, busy_cnt and hz_err. The storage array, write logic and read/bypass muxes stay in the top.

Test Plan:
- rst=1 mid-run after writing x5=0x1234 -> rs_data reads 0 and busy_cnt=0 immediately, without a clock edge.
- ZERO_REG=1: we_a x0=0xDEAD, rsv_valid x0 -> rs_data(x0)=0, busy_vec=0, hz_err=0. Repeat with ZERO_REG=0 -> f0 reads 0xDEAD and busy_vec[0]=1.
- Same-cycle we_a x7=0xAAAA and we_b x7=0xBBBB, rs_addr0=x7 -> rs_data0=0xAAAA that cycle, stored value 0xAAAA afterwards, hz_err=1.
- rsv x9 -> rs_busy=1 for a port reading x9; later we_b x9=0x55 -> rs_busy=0 and rs_data=0x55 in that same cycle; busy_cnt goes 0->1->0.
- Same cycle rsv x3 and we_b x3 with x3 busy -> x3 remains busy, busy_cnt unchanged, hz_err=0.
- Reserve x1, x2, x3 (busy_cnt=3), then flush together with rsv x4 -> busy_vec=0, busy_cnt=0; then we_b x2 with flush=0 -> hz_err=1.
